// File: rtl/decim_avg.sv
// rtl/decim_avg.sv - Decimating block averager with output FIFO and sticky overrun.
// Define DECIM_ROUND_EN for round-half-up averaging with positive saturation.
module decim_avg #(
  parameter int DECIM_LOG2 = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic signed [15:0]            data_i,
  input  logic                          valid_i,
  input  logic                          clear_i,
  output logic signed [15:0]            data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overrun_o
);

  localparam int ACC_W = 16 + DECIM_LOG2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [DECIM_LOG2-1:0] PHASE_MAX = '1;

  logic [DECIM_LOG2-1:0]    phase_q, phase_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic                     overrun_q, overrun_d;
  logic signed [15:0]       data_q, data_d;
  logic signed [15:0]       mem_q [FIFO_DEPTH];

  logic                     accept, last, push_req, pop, full, do_push;
  logic signed [ACC_W-1:0]  data_ext, sum_w;
  logic signed [15:0]       avg_w;

  assign data_ext = {{DECIM_LOG2{data_i[15]}}, data_i};
  assign sum_w    = acc_q + data_ext;

`ifdef DECIM_ROUND_EN
  localparam int HALF = 1 << (DECIM_LOG2 - 1);
  logic signed [ACC_W:0] rsum_w, rshift_w;

  // One extra bit keeps the rounding add from wrapping at full-scale positive input.
  always_comb begin
    rsum_w   = $signed({sum_w[ACC_W-1], sum_w}) + $signed((ACC_W+1)'(HALF));
    rshift_w = rsum_w >>> DECIM_LOG2;
    avg_w    = (rshift_w > $signed((ACC_W+1)'(32767))) ? 16'sd32767 : rshift_w[15:0];
  end
`else
  // Arithmetic shift then truncate to 16 bits is just the top slice of the sum.
  assign avg_w = sum_w[DECIM_LOG2 +: 16];
`endif

  always_comb begin
    accept   = valid_i & ~clear_i;
    last     = (phase_q == PHASE_MAX);
    push_req = accept & last;
    pop      = valid_o & ready_i & ~clear_i;
    full     = (level_q == LVL_W'(FIFO_DEPTH));
    do_push  = push_req & (~full | pop);

    phase_d   = phase_q;
    acc_d     = acc_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    overrun_d = overrun_q;
    data_d    = data_q;

    if (clear_i) begin
      phase_d   = '0;
      acc_d     = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      overrun_d = 1'b0;
    end else begin
      if (accept) begin
        phase_d = last ? '0 : phase_q + DECIM_LOG2'(1);
        acc_d   = (phase_q == '0) ? data_ext : sum_w;
      end
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !pop)      level_d = level_q + LVL_W'(1);
      else if (pop && !do_push) level_d = level_q - LVL_W'(1);
      if (push_req && full && !pop) overrun_d = 1'b1;

      // data_o is a registered copy of the next head so it holds once the FIFO drains.
      if (do_push && (level_q == '0 || (pop && level_q == LVL_W'(1))))
        data_d = avg_w;
      else if (pop && level_q > LVL_W'(1))
        data_d = mem_q[rd_ptr_q + PTR_W'(1)];
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      phase_q   <= '0;
      acc_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
      data_q    <= '0;
    end else begin
      phase_q   <= phase_d;
      acc_q     <= acc_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      overrun_q <= overrun_d;
      data_q    <= data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= avg_w;
  end

  assign data_o    = data_q;
  assign valid_o   = (level_q != '0);
  assign level_o   = level_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_decim_avg.sv
// tb/tb_decim_avg.sv - Directed self-checking bench for decim_avg (N=8, FIFO_DEPTH=4).
module tb_decim_avg;

`ifdef DECIM_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic               clk_i = 1'b0;
  logic               reset_ni = 1'b0;
  logic signed [15:0] data_i = '0;
  logic               valid_i = 1'b0;
  logic               clear_i = 1'b0;
  logic               ready_i = 1'b0;
  logic signed [15:0] data_o;
  logic               valid_o;
  logic [2:0]         level_o;
  logic               overrun_o;

  int checks = 0;
  int errors = 0;

  decim_avg #(.DECIM_LOG2(3), .FIFO_DEPTH(4)) dut (
    .clk_i     (clk_i),
    .reset_ni  (reset_ni),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .clear_i   (clear_i),
    .data_o    (data_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .level_o   (level_o),
    .overrun_o (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sample(input int d);
    data_i  = 16'(d);
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic send_n(input int d, input int n);
    for (int i = 0; i < n; i++) sample(d);
  endtask

  task automatic pop_check(input string tag, input int exp);
    chk({tag, "_valid"}, int'(valid_o), 1);
    chk({tag, "_data"}, int'(data_o), exp);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_data", int'(data_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_level", int'(level_o), 0);
    chk("rst_overrun", int'(overrun_o), 0);
    tick();
    reset_ni = 1'b1;
    tick();

    // Eight samples of +100 with ready held high.
    ready_i = 1'b1;
    send_n(100, 7);
    chk("p100_early_valid", int'(valid_o), 0);
    sample(100);
    chk("p100_valid", int'(valid_o), 1);
    chk("p100_data", int'(data_o), 100);
    chk("p100_level", int'(level_o), 1);
    tick();
    chk("p100_valid_drop", int'(valid_o), 0);
    chk("p100_level_drop", int'(level_o), 0);
    ready_i = 1'b0;

    // -1 followed by seven zeros.
    sample(-1);
    send_n(0, 7);
    pop_check("neg1", ROUND ? 0 : -1);

    // 1..8 sums to 36: average 4.5.
    for (int i = 1; i <= 8; i++) sample(i);
    pop_check("ramp", ROUND ? 5 : 4);

    // -5,-7 then zeros sums to -12: average -1.5.
    sample(-5);
    sample(-7);
    send_n(0, 6);
    pop_check("neg_half", ROUND ? -1 : -2);

    send_n(32767, 8);
    pop_check("pos_full", 32767);
    send_n(-32768, 8);
    pop_check("neg_full", -32768);
    chk("idle_level", int'(level_o), 0);

    // Five averages into a four-entry FIFO with ready low.
    for (int k = 1; k <= 5; k++) send_n(k, 8);
    chk("ovr_level", int'(level_o), 4);
    chk("ovr_flag", int'(overrun_o), 1);
    chk("ovr_head_stable", int'(data_o), 1);
    tick();
    chk("ovr_head_hold", int'(data_o), 1);
    for (int k = 1; k <= 4; k++) pop_check("ovr_pop", k);
    chk("ovr_empty", int'(valid_o), 0);
    chk("ovr_sticky", int'(overrun_o), 1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("ovr_cleared", int'(overrun_o), 0);

    // Full FIFO with push and pop on the same edge.
    for (int k = 1; k <= 4; k++) send_n(10 * k, 8);
    chk("fullpp_pre_level", int'(level_o), 4);
    send_n(50, 7);
    ready_i = 1'b1;
    sample(50);
    ready_i = 1'b0;
    chk("fullpp_level", int'(level_o), 4);
    chk("fullpp_overrun", int'(overrun_o), 0);
    for (int k = 2; k <= 5; k++) pop_check("fullpp_pop", 10 * k);
    chk("fullpp_empty", int'(level_o), 0);

    // Reset in mid-accumulation at phase 5.
    send_n(1000, 5);
    reset_ni = 1'b0;
    #1;
    chk("midrst_data", int'(data_o), 0);
    chk("midrst_valid", int'(valid_o), 0);
    chk("midrst_overrun", int'(overrun_o), 0);
    tick();
    tick();
    tick();
    reset_ni = 1'b1;
    tick();
    send_n(7, 7);
    chk("midrst_no_early", int'(valid_o), 0);
    sample(7);
    chk("midrst_level", int'(level_o), 1);
    pop_check("midrst_out", 7);

    // Clear in mid-accumulation at phase 5; the sample on the clear edge is ignored.
    send_n(1000, 5);
    clear_i = 1'b1;
    data_i  = 16'sd1000;
    valid_i = 1'b1;
    tick();
    clear_i = 1'b0;
    valid_i = 1'b0;
    chk("midclr_level", int'(level_o), 0);
    send_n(7, 7);
    chk("midclr_no_early", int'(valid_o), 0);
    sample(7);
    chk("midclr_level1", int'(level_o), 1);
    pop_check("midclr_out", 7);
    chk("final_level", int'(level_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decim_avg.md
DECIM_AVG -- requirements
Module: decim_avg

Interface
REQ-001 Parameter DECIM_LOG2, default 3: decimation ratio N = 2^DECIM_LOG2, legal range 1..6.
REQ-002 Parameter FIFO_DEPTH, default 4: output FIFO entries, power of two, legal range 2..16.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_ni  input  1  asynchronous, active-low reset.
REQ-005 data_i  input  16  signed filtered sample from the upstream IIR filter stage.
REQ-006 valid_i  input  1  data_i is a new sample this cycle.
REQ-007 clear_i  input  1  synchronous flush of the accumulator, phase counter, FIFO and overrun flag.
REQ-008 data_o  output  16  signed decimated average at the FIFO head.
REQ-009 valid_o  output  1  FIFO is non-empty and data_o is valid.
REQ-010 ready_i  input  1  downstream accepts data_o this cycle.
REQ-011 level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-012 overrun_o  output  1  sticky flag: an average was dropped because the FIFO was full.

Function
REQ-013 Sample acceptance: a sample is accepted on a rising edge where valid_i=1 and clear_i=0; valid_i is never back-pressured.
REQ-014 Accumulator: width 16+DECIM_LOG2 bits, signed, sign-extends every input, cannot overflow.
REQ-015 Phase counter: DECIM_LOG2 bits; it counts accepted samples from 0 to N-1 and wraps to 0 on the Nth sample.
REQ-016 Sample at phase 0: the accumulator loads the sign-extended data_i.
REQ-017 Samples at phases 1..N-1: the accumulator adds data_i.
REQ-018 Nth sample (phase N-1): the average is computed combinationally from accumulator+data_i and pushed into the FIFO on the same edge.
REQ-019 Average computation: sum arithmetic-shifted right by DECIM_LOG2 (truncation toward minus infinity), except as modified by REQ-030.
REQ-020 Latency: valid_o rises one clock after the edge that accepts the Nth sample, when the FIFO was empty.
REQ-021 Pop: occurs on an edge where valid_o=1 and ready_i=1; data_o is the oldest entry (first-in first-out); data_o stays stable while valid_o=1 and ready_i=0.
REQ-022 Full FIFO, no pop: a push is dropped, FIFO contents are unchanged, and overrun_o is set and held until clear_i or reset.
REQ-023 Full FIFO, simultaneous pop: push and pop both occur, level is unchanged, and overrun_o is not set.
REQ-024 Empty FIFO, simultaneous push: the push occurs, level becomes 1, and ready_i has no effect.
REQ-025 FIFO pointers: wrap modulo FIFO_DEPTH; level_o equals pushes minus pops and is never above FIFO_DEPTH.
REQ-026 clear_i=1: on that edge the phase counter, accumulator, FIFO level and overrun_o go to 0; any sample and any pop that cycle are ignored.
REQ-027 valid_o=0: data_o holds its last value; its value carries no meaning.

Reset
REQ-028 reset_ni=0: asynchronously drives data_o=0, valid_o=0, level_o=0 and overrun_o=0, and clears the accumulator, phase counter and FIFO pointers; all outputs are deterministic while reset is held.
REQ-029 Reset deassertion: the first sample accepted afterwards is phase 0; a partial accumulation in progress at reset is discarded.

Configuration
REQ-030 Macro DECIM_ROUND_EN defined: average = (sum + 2^(DECIM_LOG2-1)) >>> DECIM_LOG2 (round half up), saturated to +32767.
REQ-031 Macro DECIM_ROUND_EN undefined: the truncating average of REQ-019 is used, with no rounding adder and no saturation logic.

Verification
REQ-032 N=8, eight samples of +100 with valid_i every cycle and ready_i=1 -> valid_o for one cycle starting one clock after the 8th sample, data_o=100, level_o returns to 0.
REQ-033 N=8, samples -1,0,0,0,0,0,0,0 -> data_o=-1 without DECIM_ROUND_EN; data_o=0 with DECIM_ROUND_EN.
REQ-034 N=8, eight samples of +32767 with DECIM_ROUND_EN -> data_o=32767, with no wrap to negative.
REQ-035 ready_i=0, 40 samples of value k per group (5 averages, FIFO_DEPTH=4) -> level_o=4, overrun_o=1, and the first four averages pop out in order once ready_i=1.
REQ-036 FIFO full, 8th sample edge coincides with ready_i=1 -> level_o stays 4, overrun_o stays 0.
REQ-037 reset_ni pulsed low for a few cycles at phase 5, then 8 samples of 7 -> a single output of 7 with no stale partial sum; repeat with clear_i=1 at phase 5 -> same result.
